// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem -- AHB-Lite slave with word-organised on-chip storage.
//
// Accepts single transfers (hburst is ignored) with optional wait states. It
// flags range, size and alignment violations with the two-cycle AHB ERROR
// response. Writes are committed on the edge that ends the data phase, so a
// read issued right behind a write to the same word sees the new bytes.
//
// Ports:
//   hclk, hreset          rising-edge clock, synchronous active-high reset
//   hsel, haddr, htrans   address-phase select, byte address, transfer type
//   hburst, hsize, hwrite burst type (unused), transfer size, direction
//   hwdata                write data, valid in the data phase
//   hwstrb                per-byte write strobes, data phase (AHB5_HWSTRB_EN only)
//   hready                bus-level ready from the interconnect
//   hreadyout, hresp      slave ready and response (0=OKAY, 1=ERROR)
//   hrdata                read data, zero outside a completing read data phase
//
// Optional feature: define AHB5_HWSTRB_EN to add the hwstrb input. The
// written byte lanes are then the size/address lanes ANDed with hwstrb.
//
// Supported configurations: DATAWIDTH must be at least 16.
module ahb_slv_mem #(
    parameter int ADDRWIDTH   = 32,
    parameter int DATAWIDTH   = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic                   hsel,
    input  logic [ADDRWIDTH-1:0]   haddr,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic [2:0]             hsize,
    input  logic                   hwrite,
    input  logic [DATAWIDTH-1:0]   hwdata,
`ifdef AHB5_HWSTRB_EN
    input  logic [DATAWIDTH/8-1:0] hwstrb,
`endif
    input  logic                   hready,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [DATAWIDTH-1:0]   hrdata
);

    localparam int NB     = DATAWIDTH / 8;
    localparam int BSHIFT = $clog2(NB);
    localparam int IDXW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Counter preload. A zero-wait build never enters WAIT, so its value is irrelevant.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0]           state;
    logic [3:0]           wait_cnt;
    logic                 dp_valid;
    logic                 dp_write;
    logic [2:0]           dp_size;
    logic [BSHIFT-1:0]    dp_low;
    logic [IDXW-1:0]      dp_index;

    logic [DATAWIDTH-1:0] mem [MEM_DEPTH];

    logic                 accept;
    logic                 range_err;
    logic                 size_err;
    logic                 align_err;
    logic                 acc_err;
    logic                 data_done;
    logic [ADDRWIDTH-1:0] word_addr;
    logic [NB-1:0]        lane_sel;
    logic [NB-1:0]        wr_lanes;

    // Burst type and the SEQ/NONSEQ distinction do not affect a single-word slave.
    logic unused_inputs;
    assign unused_inputs = ^{hburst, htrans[0]};

    // Only the IDLE state has hreadyout=1 with no error in progress, so accepting
    // only there also guarantees nothing is taken while hreadyout is low. Masters
    // are expected to drive IDLE during the second ERROR cycle.
    assign accept = hsel && hready && htrans[1] && (state == S_IDLE);

    assign word_addr = haddr >> BSHIFT;
    assign range_err = word_addr >= ADDRWIDTH'(MEM_DEPTH);
    assign size_err  = hsize > 3'(BSHIFT);

    always_comb begin
        align_err = 1'b0;
        for (int i = 0; i < BSHIFT; i++) begin
            if (i < int'(hsize) && haddr[i]) begin
                align_err = 1'b1;
            end
        end
    end

    assign acc_err = range_err || size_err || align_err;

    // A registered, error-free transfer completes in the first IDLE cycle after
    // its accept (zero wait) or after the WAIT countdown.
    assign data_done = (state == S_IDLE) && dp_valid;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_size  <= 3'd0;
            dp_low   <= '0;
            dp_index <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (acc_err) begin
                            state <= S_ERR1;
                        end else if (WAIT_STATES > 0) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end
                end
                S_ERR1:  state <= S_ERR2;
                default: state <= S_IDLE;
            endcase

            // An errored accept leaves no data phase pending, so storage is never touched.
            if (state == S_IDLE) begin
                dp_valid <= accept && !acc_err;
            end

            if (accept) begin
                dp_write <= hwrite;
                dp_size  <= hsize;
                dp_low   <= haddr[BSHIFT-1:0];
                dp_index <= haddr[BSHIFT +: IDXW];
            end

            if (accept && !acc_err) begin
                wait_cnt <= WS_LOAD;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // A lane belongs to the transfer when it falls in the same 2^size-byte
    // aligned group as the registered address.
    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < NB; i++) begin
            lane_sel[i] = ((i >> dp_size) == (int'(dp_low) >> dp_size));
        end
    end

`ifdef AHB5_HWSTRB_EN
    assign wr_lanes = lane_sel & hwstrb;
`else
    assign wr_lanes = lane_sel;
`endif

    // Storage is deliberately not reset; a reset edge only suppresses the commit.
    always_ff @(posedge hclk) begin
        if (!hreset && data_done && dp_write) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_lanes[i]) begin
                    mem[dp_index][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign hreadyout = (state == S_IDLE) || (state == S_ERR2);
    assign hresp     = (state == S_ERR1) || (state == S_ERR2);
    assign hrdata    = (data_done && !dp_write) ? mem[dp_index] : '0;

endmodule

// File: tb/tb_ahb_slv_mem.sv
// tb_ahb_slv_mem -- self-checking bench for ahb_slv_mem.
//
// Three instances share one bus (WAIT_STATES = 0, 3 and 5), each selected by its
// own hsel bit. Each instance has its hready tied to its own hreadyout.
// A byte-array model predicts hreadyout/hresp/hrdata for every cycle of every
// transfer. A single negedge process compares the selected instance against it.
// Define AHB5_HWSTRB_EN to include the write-strobe case.
module tb_ahb_slv_mem;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  strb;
    } xfer_t;

    logic        hclk   = 1'b0;
    logic        hreset = 1'b1;
    logic [2:0]  hsel_v = 3'b000;
    logic [31:0] haddr  = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hburst = 3'b000;
    logic [2:0]  hsize  = 3'b000;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = 32'h0;
`ifdef AHB5_HWSTRB_EN
    logic [3:0]  hwstrb = 4'h0;
`endif
    logic [2:0]  rdy_v;
    logic [2:0]  resp_v;
    logic [31:0] rd_v [3];

    int          ws_of [3] = '{0, 3, 5};
    logic [7:0]  mdl [3][4096];
    xfer_t       pend [$];

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    int          sel = 0;
    logic        exp_rdy = 1'b1;
    logic        exp_resp = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    bit          exp_rd_phase = 1'b0;
    logic [31:0] last_rd = 32'h0;
    int          low_cnt = 0;
    int          err_cnt = 0;

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_slv_mem #(
            .ADDRWIDTH  (32),
            .DATAWIDTH  (32),
            .MEM_DEPTH  (1024),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 5))
        ) dut (
            .hclk     (hclk),
            .hreset   (hreset),
            .hsel     (hsel_v[g]),
            .haddr    (haddr),
            .htrans   (htrans),
            .hburst   (hburst),
            .hsize    (hsize),
            .hwrite   (hwrite),
            .hwdata   (hwdata),
`ifdef AHB5_HWSTRB_EN
            .hwstrb   (hwstrb),
`endif
            .hready   (rdy_v[g]),
            .hreadyout(rdy_v[g]),
            .hresp    (resp_v[g]),
            .hrdata   (rd_v[g])
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit modelErr(input xfer_t t);
        int unsigned bytes;
        bytes = 32'd1 << t.size;
        return ((t.addr / 32'd4) >= 32'd1024) || (bytes > 32'd4) || ((t.addr % bytes) != 32'd0);
    endfunction

    function automatic logic [31:0] modelRead(input int inst, input logic [31:0] addr);
        int base;
        base = int'(addr & 32'hFFFF_FFFC);
        return {mdl[inst][base+3], mdl[inst][base+2], mdl[inst][base+1], mdl[inst][base]};
    endfunction

    task automatic modelWrite(input int inst, input xfer_t t);
        int base;
        int lo;
        int bytes;
        logic [3:0] eff;
        base  = int'(t.addr & 32'hFFFF_FFFC);
        lo    = int'(t.addr % 32'd4);
        bytes = 1 << t.size;
`ifdef AHB5_HWSTRB_EN
        eff = t.strb;
`else
        eff = 4'hF;
`endif
        for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + bytes && eff[b]) begin
                mdl[inst][base+b] = t.data[8*b +: 8];
            end
        end
    endtask

    task automatic queueXfer(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                             input logic [31:0] data, input logic [3:0] strb);
        xfer_t t;
        t.addr = addr;
        t.size = size;
        t.wr   = wr;
        t.data = data;
        t.strb = strb;
        pend.push_back(t);
    endtask

    task automatic setIdleExpect();
        exp_rdy      = 1'b1;
        exp_resp     = 1'b0;
        exp_rdata    = 32'h0;
        exp_rd_phase = 1'b0;
    endtask

    // Runs the queued transfers back-to-back on one instance, one loop pass per clock.
    task automatic applyStimulus(input int inst);
        xfer_t cur;
        bit    have_cur = 1'b0;
        bit    cur_err  = 1'b0;
        bit    pres;
        int    left  = 0;
        int    guard = 0;
        sel    = inst;
        chk_en = 1'b1;
        do begin
            exp_rd_phase = 1'b0;
            if (have_cur && cur_err) begin
                exp_rdy   = (left == 1);
                exp_resp  = 1'b1;
                exp_rdata = 32'h0;
            end else if (have_cur && left > 1) begin
                exp_rdy   = 1'b0;
                exp_resp  = 1'b0;
                exp_rdata = 32'h0;
            end else if (have_cur) begin
                exp_rdy      = 1'b1;
                exp_resp     = 1'b0;
                exp_rdata    = cur.wr ? 32'h0 : modelRead(inst, cur.addr);
                exp_rd_phase = !cur.wr;
            end else begin
                setIdleExpect();
            end
            hwdata = (have_cur && cur.wr) ? cur.data : 32'h0;
`ifdef AHB5_HWSTRB_EN
            hwstrb = (have_cur && cur.wr) ? cur.strb : 4'h0;
`endif
            pres   = (pend.size() > 0) && !(have_cur && cur_err);
            hsel_v = 3'(1 << inst);
            if (pres) begin
                haddr  = pend[0].addr;
                hsize  = pend[0].size;
                hwrite = pend[0].wr;
                htrans = 2'b10;
            end else begin
                htrans = 2'b00;
                hwrite = 1'b0;
            end
            @(negedge hclk);
            @(posedge hclk);
            #1;
            if (have_cur) begin
                if (!cur_err && left == 1 && cur.wr) begin
                    modelWrite(inst, cur);
                end
                left--;
                if (left == 0) begin
                    have_cur = 1'b0;
                end
            end
            if (pres && exp_rdy) begin
                cur      = pend.pop_front();
                cur_err  = modelErr(cur);
                left     = cur_err ? 2 : ws_of[inst] + 1;
                have_cur = 1'b1;
            end
            guard++;
        end while ((have_cur || pend.size() > 0) && guard < 200);
        checkOutput("seq_drain", 32'(pend.size() + int'(have_cur)), 32'h0);
        pend.delete();
        htrans = 2'b00;
        hwrite = 1'b0;
        hsel_v = 3'b000;
        hwdata = 32'h0;
        setIdleExpect();
    endtask

    always @(negedge hclk) begin
        if (chk_en) begin
            checkOutput("hreadyout", 32'(rdy_v[sel]), 32'(exp_rdy));
            checkOutput("hresp", 32'(resp_v[sel]), 32'(exp_resp));
            checkOutput("hrdata", rd_v[sel], exp_rdata);
            if (exp_rd_phase) last_rd = rd_v[sel];
            if (!rdy_v[sel]) low_cnt++;
            if (resp_v[sel]) err_cnt++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4096; j++)
                mdl[i][j] = 8'h00;

        // Reset state.
        repeat (2) @(posedge hclk);
        #1;
        @(negedge hclk);
        for (int g = 0; g < 3; g++) begin
            checkOutput("rst_hreadyout", 32'(rdy_v[g]), 32'h1);
            checkOutput("rst_hresp", 32'(resp_v[g]), 32'h0);
            checkOutput("rst_hrdata", rd_v[g], 32'h0);
        end
        @(posedge hclk);
        #1;
        hreset = 1'b0;

        // Zero-wait write then back-to-back read.
        queueXfer(32'h10, 3'd2, 1'b1, 32'hDEADBEEF, 4'hF);
        queueXfer(32'h10, 3'd2, 1'b0, 32'h0, 4'hF);
        applyStimulus(0);
        checkOutput("mdl_deadbeef", modelRead(0, 32'h10), 32'hDEADBEEF);
        checkOutput("rd_deadbeef", last_rd, 32'hDEADBEEF);

        // Byte write over a cleared word.
        queueXfer(32'h10, 3'd2, 1'b1, 32'h0, 4'hF);
        queueXfer(32'h13, 3'd0, 1'b1, 32'hAB00_0000, 4'hF);
        queueXfer(32'h10, 3'd2, 1'b0, 32'h0, 4'hF);
        applyStimulus(0);
        checkOutput("rd_byte13", last_rd, 32'hAB00_0000);

        // Halfword merge, then a run of byte writes filling two words.
        queueXfer(32'h14, 3'd2, 1'b1, 32'h1122_3344, 4'hF);
        queueXfer(32'h16, 3'd1, 1'b1, 32'h5566_0000, 4'hF);
        queueXfer(32'h14, 3'd2, 1'b0, 32'h0, 4'hF);
        applyStimulus(0);
        checkOutput("rd_half16", last_rd, 32'h5566_3344);
        for (int i = 0; i < 8; i++)
            queueXfer(32'h200 + 32'(i), 3'd0, 1'b1, 32'((i + 1) * 17) << (8 * (i % 4)), 4'hF);
        queueXfer(32'h200, 3'd2, 1'b0, 32'h0, 4'hF);
        queueXfer(32'h204, 3'd2, 1'b0, 32'h0, 4'hF);
        applyStimulus(0);
        checkOutput("mdl_bytes200", modelRead(0, 32'h200), 32'h4433_2211);
        checkOutput("rd_bytes204", last_rd, 32'h8877_6655);

        // Error responses leave storage untouched.
        queueXfer(32'h0, 3'd2, 1'b1, 32'h0BAD_F00D, 4'hF);
        applyStimulus(0);
        err_cnt = 0;
        queueXfer(32'h1000, 3'd2, 1'b0, 32'h0, 4'hF);
        queueXfer(32'h01, 3'd1, 1'b1, 32'hFFFF_FFFF, 4'hF);
        queueXfer(32'h00, 3'd3, 1'b1, 32'hFFFF_FFFF, 4'hF);
        queueXfer(32'h10, 3'd2, 1'b0, 32'h0, 4'hF);
        queueXfer(32'h00, 3'd2, 1'b0, 32'h0, 4'hF);
        applyStimulus(0);
        checkOutput("err_cycles", 32'(err_cnt), 32'd6);
        checkOutput("rd_after_err", last_rd, 32'h0BAD_F00D);

        // Three wait states.
        queueXfer(32'h20, 3'd2, 1'b1, 32'h55AA_55AA, 4'hF);
        applyStimulus(1);
        low_cnt = 0;
        queueXfer(32'h20, 3'd2, 1'b0, 32'h0, 4'hF);
        applyStimulus(1);
        checkOutput("ws3_low_cycles", 32'(low_cnt), 32'd3);
        checkOutput("ws3_rd", last_rd, 32'h55AA_55AA);
        queueXfer(32'h24, 3'd2, 1'b1, 32'h0F0F_0F0F, 4'hF);
        queueXfer(32'h24, 3'd2, 1'b0, 32'h0, 4'hF);
        applyStimulus(1);
        checkOutput("ws3_b2b_rd", last_rd, 32'h0F0F_0F0F);

        // Reset in the second wait cycle of a five-wait write drops it.
        queueXfer(32'h40, 3'd2, 1'b1, 32'hCAFE_F00D, 4'hF);
        applyStimulus(2);
        chk_en = 1'b0;
        sel    = 2;
        hsel_v = 3'b100;
        haddr  = 32'h40;
        hsize  = 3'd2;
        hwrite = 1'b1;
        htrans = 2'b10;
        @(posedge hclk);
        #1;
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = 32'h1234_5678;
        @(negedge hclk);
        checkOutput("ws5_wait1_rdy", 32'(rdy_v[2]), 32'h0);
        @(posedge hclk);
        #1;
        hreset = 1'b1;
        @(negedge hclk);
        checkOutput("ws5_wait2_rdy", 32'(rdy_v[2]), 32'h0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(negedge hclk);
        checkOutput("post_rst_rdy", 32'(rdy_v[2]), 32'h1);
        checkOutput("post_rst_resp", 32'(resp_v[2]), 32'h0);
        @(posedge hclk);
        #1;
        hwdata = 32'h0;
        hsel_v = 3'b000;
        setIdleExpect();
        queueXfer(32'h40, 3'd2, 1'b0, 32'h0, 4'hF);
        applyStimulus(2);
        checkOutput("ws5_old_value", last_rd, 32'hCAFE_F00D);

`ifdef AHB5_HWSTRB_EN
        // Strobed word write.
        queueXfer(32'h80, 3'd2, 1'b1, 32'h0, 4'hF);
        queueXfer(32'h80, 3'd2, 1'b1, 32'hFFFF_FFFF, 4'b0101);
        queueXfer(32'h80, 3'd2, 1'b0, 32'h0, 4'hF);
        applyStimulus(0);
        checkOutput("strb_rd", last_rd, 32'h00FF_00FF);
`endif

        repeat (2) @(posedge hclk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
